// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB types and constants for the two-master arbiter:
//   htrans_t     - AHB transfer type encoding
//   master_id_t  - one-bit master identifier
//   MASTER_CPU / MASTER_DMA - identifiers of the two masters
//   htrans_active - true when a transfer type completes a real beat
// ----------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef logic master_id_t;

    localparam master_id_t MASTER_CPU = 1'b0;
    localparam master_id_t MASTER_DMA = 1'b1;

    // NONSEQ and SEQ are the only transfer types that move data.
    function automatic logic htrans_active(input logic [1:0] trans);
        return (trans == NONSEQ) || (trans == SEQ);
    endfunction

endpackage

// File: rtl/ahb_grant_fsm.sv
// ----------------------------------------------------------------------------
// ahb_grant_fsm
// Grant decision and hold-limit counter for the two-master AHB arbiter.
// Ports:
//   clk_i          - bus clock
//   rst_ni         - synchronous active-low reset
//   hready_i       - shared HREADY; the decision advances only when high
//   busreq_i[1:0]  - bus request, indexed by master id
//   mastlock_i[1:0]- locked-transfer flag, indexed by master id
//   addr_owner_i   - master currently owning the address phase
//   addr_htrans_i  - HTRANS driven by the address-phase owner
//   grant_o        - registered grant (master id)
// ----------------------------------------------------------------------------
module ahb_grant_fsm
    import ahb_pkg::*;
#(
    parameter int HOLD_BEATS     = 8,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hready_i,
    input  logic [1:0] busreq_i,
    input  logic [1:0] mastlock_i,
    input  master_id_t addr_owner_i,
    input  logic [1:0] addr_htrans_i,
    output master_id_t grant_o
);

    localparam int             CNT_W    = $clog2(HOLD_BEATS + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_BEATS);
    localparam master_id_t     DEF_M    = (DEFAULT_MASTER != 0) ? MASTER_DMA : MASTER_CPU;

    master_id_t       grant_q, grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    master_id_t       other_s;

    // Next grant (first matching rule wins) and beat counting.
    always_comb begin
        other_s    = ~grant_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        if (hready_i) begin
            // A lock held by either the address-phase owner or the granted
            // master pins the grant and overrides the hold limit.
            if (mastlock_i[addr_owner_i] || mastlock_i[grant_q]) begin
                grant_d = grant_q;
            end else if (busreq_i[grant_q] &&
                         (!busreq_i[other_s] || (beat_cnt_q < HOLD_MAX))) begin
                grant_d = grant_q;
            end else if (busreq_i[other_s]) begin
                grant_d = other_s;
            end else begin
                grant_d = DEF_M;
            end

            // A handover restarts the count so the new owner gets a full quota.
            if (grant_d != grant_q) begin
                beat_cnt_d = '0;
            end else if (htrans_active(addr_htrans_i) && (beat_cnt_q < HOLD_MAX)) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end else begin
                beat_cnt_d = beat_cnt_q;
            end
        end else begin
            grant_d    = grant_q;
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Grant and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            grant_q    <= DEF_M;
            beat_cnt_q <= '0;
        end else begin
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_o = grant_q;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_bus_arbiter
// Two-master AHB arbiter and bus multiplexer (master 0 = CPU, master 1 = DMA).
// Ports:
//   HCLK, HRESETn              - clock, synchronous active-low reset
//   HBUSREQ_Mx / HGRANT_Mx     - request in, registered grant out
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HWDATA_Mx - master buses
//   HADDR ... HWDATA, HMASTLOCK - shared bus toward the interconnect
//   HREADY                     - shared ready; ownership moves only when high
//   HMASTER                    - current address-phase owner
// ----------------------------------------------------------------------------
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int HOLD_BEATS     = 8,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HBUSREQ_M0,
    input  logic        HBUSREQ_M1,
    output logic        HGRANT_M0,
    output logic        HGRANT_M1,
    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic [2:0]  HSIZE_M0,
    input  logic [2:0]  HBURST_M0,
    input  logic [3:0]  HPROT_M0,
    input  logic        HMASTLOCK_M0,
    input  logic [31:0] HWDATA_M0,
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [2:0]  HBURST_M1,
    input  logic [3:0]  HPROT_M1,
    input  logic        HMASTLOCK_M1,
    input  logic [31:0] HWDATA_M1,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HMASTER
);

    localparam master_id_t DEF_M = (DEFAULT_MASTER != 0) ? MASTER_DMA : MASTER_CPU;

    master_id_t grant_s;
    master_id_t addr_owner_q, addr_owner_d;
    master_id_t data_owner_q, data_owner_d;

    ahb_grant_fsm #(
        .HOLD_BEATS     (HOLD_BEATS),
        .DEFAULT_MASTER (DEFAULT_MASTER)
    ) u_grant_fsm (
        .clk_i         (HCLK),
        .rst_ni        (HRESETn),
        .hready_i      (HREADY),
        .busreq_i      ({HBUSREQ_M1, HBUSREQ_M0}),
        .mastlock_i    ({HMASTLOCK_M1, HMASTLOCK_M0}),
        .addr_owner_i  (addr_owner_q),
        .addr_htrans_i (HTRANS),
        .grant_o       (grant_s)
    );

    // Ownership pipeline: grant -> address phase -> data phase, frozen by stalls
    // so a stalled data phase keeps its HWDATA source across a handover.
    always_comb begin
        if (HREADY) begin
            addr_owner_d = grant_s;
            data_owner_d = addr_owner_q;
        end else begin
            addr_owner_d = addr_owner_q;
            data_owner_d = data_owner_q;
        end
    end

    // Owner registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            addr_owner_q <= DEF_M;
            data_owner_q <= DEF_M;
        end else begin
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
        end
    end

    // Address/control mux on the address-phase owner, write data on the data-phase owner.
    always_comb begin
        if (addr_owner_q == MASTER_DMA) begin
            HADDR     = HADDR_M1;
            HTRANS    = HTRANS_M1;
            HWRITE    = HWRITE_M1;
            HSIZE     = HSIZE_M1;
            HBURST    = HBURST_M1;
            HPROT     = HPROT_M1;
            HMASTLOCK = HMASTLOCK_M1;
        end else begin
            HADDR     = HADDR_M0;
            HTRANS    = HTRANS_M0;
            HWRITE    = HWRITE_M0;
            HSIZE     = HSIZE_M0;
            HBURST    = HBURST_M0;
            HPROT     = HPROT_M0;
            HMASTLOCK = HMASTLOCK_M0;
        end
        if (data_owner_q == MASTER_DMA) begin
            HWDATA = HWDATA_M1;
        end else begin
            HWDATA = HWDATA_M0;
        end
    end

    assign HGRANT_M0 = (grant_s == MASTER_CPU);
    assign HGRANT_M1 = (grant_s == MASTER_DMA);
    assign HMASTER   = addr_owner_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_bus_arbiter
// Two arbiter instances (DEFAULT_MASTER 0 and 1) share one set of master
// stimuli. A rule-level reference model predicts grant and owners per
// instance; every cycle the shared bus outputs are compared against it,
// followed by directed scenarios and randomized traffic.
// ----------------------------------------------------------------------------
module tb_ahb_bus_arbiter;

    localparam int HOLD = 8;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        rstn;
    logic        hready;
    logic        req   [2];
    logic        lock  [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [1:0]  trans [2];
    logic [2:0]  size  [2];
    logic [2:0]  burst [2];
    logic [3:0]  prot  [2];

    logic        g0 [2], g1 [2], mst [2], o_wr [2], o_lock [2];
    logic [31:0] o_addr [2], o_wdata [2];
    logic [1:0]  o_trans [2];
    logic [2:0]  o_size [2], o_burst [2];
    logic [3:0]  o_prot [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        ahb_bus_arbiter #(
            .HOLD_BEATS     (HOLD),
            .DEFAULT_MASTER (k)
        ) u_dut (
            .HCLK         (HCLK),
            .HRESETn      (rstn),
            .HBUSREQ_M0   (req[0]),
            .HBUSREQ_M1   (req[1]),
            .HGRANT_M0    (g0[k]),
            .HGRANT_M1    (g1[k]),
            .HADDR_M0     (addr[0]),
            .HTRANS_M0    (trans[0]),
            .HWRITE_M0    (wr[0]),
            .HSIZE_M0     (size[0]),
            .HBURST_M0    (burst[0]),
            .HPROT_M0     (prot[0]),
            .HMASTLOCK_M0 (lock[0]),
            .HWDATA_M0    (wdata[0]),
            .HADDR_M1     (addr[1]),
            .HTRANS_M1    (trans[1]),
            .HWRITE_M1    (wr[1]),
            .HSIZE_M1     (size[1]),
            .HBURST_M1    (burst[1]),
            .HPROT_M1     (prot[1]),
            .HMASTLOCK_M1 (lock[1]),
            .HWDATA_M1    (wdata[1]),
            .HADDR        (o_addr[k]),
            .HTRANS       (o_trans[k]),
            .HWRITE       (o_wr[k]),
            .HSIZE        (o_size[k]),
            .HBURST       (o_burst[k]),
            .HPROT        (o_prot[k]),
            .HMASTLOCK    (o_lock[k]),
            .HWDATA       (o_wdata[k]),
            .HREADY       (hready),
            .HMASTER      (mst[k])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference state per instance: grant, address owner, data owner, beat count.
    int dm [2] = '{0, 1};
    int mg [2], ma [2], md [2], mc [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply the arbitration rules to the model at one rising edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int c, o, ng;
            c = mg[k];
            o = 1 - c;
            if (!rstn) begin
                mg[k] = dm[k]; ma[k] = dm[k]; md[k] = dm[k]; mc[k] = 0;
            end else if (hready) begin
                if (lock[ma[k]] || lock[c])              ng = c;
                else if (req[c] && !req[o])              ng = c;
                else if (req[c] && req[o] && mc[k] < HOLD) ng = c;
                else if (req[o])                         ng = o;
                else                                     ng = dm[k];
                if (ng != c)                mc[k] = 0;
                else if (trans[ma[k]] >= 2) mc[k] = (mc[k] < HOLD) ? mc[k] + 1 : HOLD;
                md[k] = ma[k];
                ma[k] = c;
                mg[k] = ng;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int a, d;
            a = ma[k];
            d = md[k];
            check($sformatf("d%0d_hgrant_m0", k), 32'(g0[k]), 32'(mg[k] == 0));
            check($sformatf("d%0d_hgrant_m1", k), 32'(g1[k]), 32'(mg[k] == 1));
            check($sformatf("d%0d_hmaster", k),   32'(mst[k]), 32'(a));
            check($sformatf("d%0d_haddr", k),     o_addr[k], addr[a]);
            check($sformatf("d%0d_htrans", k),    32'(o_trans[k]), 32'(trans[a]));
            check($sformatf("d%0d_hctrl", k),
                  {20'd0, o_wr[k], o_size[k], o_burst[k], o_prot[k], o_lock[k]},
                  {20'd0, wr[a], size[a], burst[a], prot[a], lock[a]});
            check($sformatf("d%0d_hwdata", k),    o_wdata[k], wdata[d]);
        end
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge.
    task automatic cyc();
        @(negedge HCLK);
        compare_all();
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    task automatic quiet_inputs();
        hready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; lock[m] = 1'b0; wr[m] = 1'b0;
            trans[m] = 2'b00; size[m] = 3'd2; burst[m] = 3'd0; prot[m] = 4'h3;
            addr[m] = 32'h1000_0000 * (m + 1); wdata[m] = 32'hA000_0000 + m;
        end
    endtask

    int first_sw, second_sw;

    initial begin
        quiet_inputs();
        rstn = 1'b0;
        @(posedge HCLK);
        model_edge();
        #1;

        // Reset
        do_reset();
        check("rst_hgrant_m0", 32'(g0[0]), 32'd1);
        check("rst_hgrant_m1", 32'(g1[0]), 32'd0);
        check("rst_hmaster",   32'(mst[0]), 32'd0);
        check("rst_haddr",     o_addr[0], addr[0]);
        check("rst_d1_hgrant_m1", 32'(g1[1]), 32'd1);

        // Single requester: M1 only
        cyc(); cyc();
        addr[1] = 32'h5000_0000; trans[1] = 2'b10; wr[1] = 1'b1; wdata[1] = 32'h1234_5678;
        req[1] = 1'b1;
        cyc();
        check("single_grant_m1", 32'(g1[0]), 32'd1);
        check("single_hmaster_early", 32'(mst[0]), 32'd0);
        cyc();
        check("single_hmaster", 32'(mst[0]), 32'd1);
        check("single_haddr", o_addr[0], 32'h5000_0000);
        cyc();
        check("single_hwdata", o_wdata[0], 32'h1234_5678);

        // Hold limit: both request, both issue NONSEQ every cycle
        quiet_inputs();
        do_reset();
        req[0] = 1'b1; req[1] = 1'b1; trans[0] = 2'b10; trans[1] = 2'b10;
        first_sw = -1; second_sw = -1;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (first_sw < 0 && g1[0] === 1'b1) first_sw = i;
            else if (first_sw >= 0 && second_sw < 0 && g0[0] === 1'b1) second_sw = i;
        end
        check("hold_first_switch", first_sw, 32'd9);
        check("hold_second_switch", second_sw - first_sw, 32'd9);

        // Stall across handover
        quiet_inputs();
        do_reset();
        req[0] = 1'b1; wr[0] = 1'b1; trans[0] = 2'b10; wdata[0] = 32'hDEAD_BEEF;
        cyc(); cyc(); cyc();
        req[0] = 1'b0; req[1] = 1'b1;
        cyc();
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_hwdata", o_wdata[0], 32'hDEAD_BEEF);
            check("stall_hmaster", 32'(mst[0]), 32'd0);
            check("stall_grant", 32'(g1[0]), 32'd1);
        end
        hready = 1'b1;
        cyc();
        check("stall_release_hmaster", 32'(mst[0]), 32'd1);
        check("stall_release_hwdata", o_wdata[0], 32'hDEAD_BEEF);

        // Lock: M0 locked for 12 beats with M1 requesting
        quiet_inputs();
        do_reset();
        req[0] = 1'b1; req[1] = 1'b1; lock[0] = 1'b1; trans[0] = 2'b10;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("lock_hold_m0", 32'(g0[0]), 32'd1);
        end
        lock[0] = 1'b0;
        cyc();
        check("lock_release_m1", 32'(g1[0]), 32'd1);

        // Park: both requests drop
        req[0] = 1'b0; req[1] = 1'b0; trans[0] = 2'b00; trans[1] = 2'b00;
        cyc(); cyc();
        check("park_def0", 32'(g0[0]), 32'd1);
        check("park_def1", 32'(g1[1]), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rstn   = ($urandom_range(199) != 0);
            hready = ($urandom_range(4) != 0);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(3) == 0) req[m] = ~req[m];
                if ($urandom_range(11) == 0) lock[m] = ~lock[m];
                trans[m] = 2'($urandom_range(3));
                wr[m]    = 1'($urandom_range(1));
                size[m]  = 3'($urandom_range(7));
                burst[m] = 3'($urandom_range(7));
                prot[m]  = 4'($urandom_range(15));
                addr[m]  = $urandom;
                wdata[m] = $urandom;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
